vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The module SHALL have parameter PRICE, default 75, item price in cents.
REQ-002 The module SHALL have parameter MAX_CREDIT, default 200, credit ceiling in cents.
REQ-003 The module SHALL have parameter CREDIT_W, default 8, credit register width in bits.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have ports penny, nickel, dime, quarter, each input, 1, a one-cycle coin-detected pulse from the coin sensor.
REQ-007 The module SHALL have port vend_req, input, 1, a purchase request level.
REQ-008 The module SHALL have port cancel, input, 1, a refund request level.
REQ-009 The module SHALL have port credit, output, CREDIT_W, current accumulated cents.
REQ-010 The module SHALL have port dispense, output, 1, a one-cycle item-release pulse.
REQ-011 The module SHALL have ports ret_quarter, ret_dime, ret_nickel, ret_penny, each output, 1, a one-cycle change-coin pulse.
REQ-012 The module SHALL have port coin_reject, output, 1, a one-cycle pulse when a coin pulse is not credited.
REQ-013 The module SHALL have port busy, output, 1, high in VEND and CHANGE.

Function
REQ-014 The FSM SHALL have states IDLE, CREDIT, VEND and CHANGE.
REQ-015 Coin values SHALL be penny 1, nickel 5, dime 10, quarter 25.
REQ-016 In IDLE or CREDIT, a coin pulse SHALL add its value to credit on the next edge and move the FSM to CREDIT.
REQ-017 When coin pulses coincide, only the highest value SHALL be credited (priority quarter > dime > nickel > penny), and coin_reject SHALL pulse once.
REQ-018 A coin that would make credit exceed MAX_CREDIT SHALL NOT be credited, and coin_reject SHALL pulse next cycle.
REQ-019 Coin pulses in VEND or CHANGE SHALL NOT be credited, and coin_reject SHALL pulse next cycle.
REQ-020 In CREDIT with vend_req=1 and credit >= PRICE, the FSM SHALL go to VEND; with credit < PRICE, vend_req SHALL be ignored.
REQ-021 VEND SHALL last exactly one cycle: dispense=1 and credit reduced by PRICE, then CHANGE if the remainder > 0, else IDLE.
REQ-022 In CREDIT with cancel=1, the FSM SHALL go to CHANGE; cancel SHALL win over vend_req and over a same-cycle coin, and that coin SHALL be rejected.
REQ-023 CHANGE SHALL emit exactly one ret_* pulse per cycle, choosing the largest coin value <= credit (greedy), and subtract that value.
REQ-024 CHANGE SHALL go to IDLE in the cycle after the pulse that brings credit to 0.
REQ-025 dispense, ret_* and coin_reject SHALL be registered outputs, mutually consistent, and never held high for two consecutive cycles by the same event.
REQ-026 All arithmetic SHALL be unsigned CREDIT_W-bit; MAX_CREDIT + 25 SHALL fit in CREDIT_W bits; overflow SHALL be impossible by REQ-018.

Reset
REQ-027 With reset=1 at an edge, the FSM SHALL go to IDLE, credit to 0, and all pulse outputs and busy to 0, from any state including mid-CHANGE, with no refund issued.
REQ-028 Coin pulses in a reset cycle SHALL be discarded without coin_reject.

Configuration
REQ-029 With macro VEND_PENNY_EN defined, pennies SHALL be credited per REQ-016.
REQ-030 Without VEND_PENNY_EN, every penny pulse SHALL be rejected with coin_reject, and ret_penny SHALL be tied to 0; PRICE SHALL then be a multiple of 5.

Structure
REQ-031 Package vend_pkg SHALL hold the state enum and the coin value constants (1, 5, 10, 25).
REQ-032 The greedy selector SHALL be sub-module vend_change_sel: input credit, outputs one-hot coin select and the coin value.

Verification
REQ-033 Quarter x3, then vend_req -> credit 75, dispense one cycle, IDLE, no ret_* pulse.
REQ-034 Quarter x4, then vend_req -> dispense, then one ret_quarter pulse, then IDLE with credit 0.
REQ-035 Dime, nickel, penny x2 (VEND_PENNY_EN), then cancel -> ret_dime, ret_nickel, ret_penny, ret_penny on consecutive cycles.
REQ-036 Credit 190, then quarter -> coin_reject and credit stays 190; dime and nickel in the same cycle -> credit 200 and one coin_reject.
REQ-037 Credit 100, cancel, reset asserted after the first ret_quarter -> credit 0, IDLE, no further ret_* pulses.
REQ-038 Penny without VEND_PENNY_EN -> coin_reject, credit unchanged.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM state codes, coin values
// and the bit positions used by every one-hot coin vector.
package vend_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CREDIT = 2'd1;
  localparam state_t ST_VEND   = 2'd2;
  localparam state_t ST_CHANGE = 2'd3;

  localparam int unsigned VAL_PENNY   = 1;
  localparam int unsigned VAL_NICKEL  = 5;
  localparam int unsigned VAL_DIME    = 10;
  localparam int unsigned VAL_QUARTER = 25;

  // Bit index of each coin inside a 4-bit one-hot coin vector.
  typedef enum logic [1:0] {
    COIN_P = 2'd0,
    COIN_N = 2'd1,
    COIN_D = 2'd2,
    COIN_Q = 2'd3
  } coin_idx_e;

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change selector: picks the largest coin whose value does not exceed
// the given credit, as a one-hot select plus the matching value.
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [3:0]          coin_sel,
  output logic [CREDIT_W-1:0] coin_val
);

  // NOTE: both outputs get a default before the priority chain so no path
  // through the block leaves them unassigned, which would infer latches.
  always_comb begin
    coin_sel = '0;
    coin_val = '0;
    if (credit >= CREDIT_W'(VAL_QUARTER)) begin
      coin_sel[COIN_Q] = 1'b1;
      coin_val         = CREDIT_W'(VAL_QUARTER);
    end else if (credit >= CREDIT_W'(VAL_DIME)) begin
      coin_sel[COIN_D] = 1'b1;
      coin_val         = CREDIT_W'(VAL_DIME);
    end else if (credit >= CREDIT_W'(VAL_NICKEL)) begin
      coin_sel[COIN_N] = 1'b1;
      coin_val         = CREDIT_W'(VAL_NICKEL);
    end else if (credit != '0) begin
      coin_sel[COIN_P] = 1'b1;
      coin_val         = CREDIT_W'(VAL_PENNY);
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Coin-operated vending controller with greedy change return.
// Define VEND_PENNY_EN to accept pennies; otherwise pennies are rejected.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE      = 75,
  parameter int unsigned MAX_CREDIT = 200,
  parameter int unsigned CREDIT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                penny,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                vend_req,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                ret_quarter,
  output logic                ret_dime,
  output logic                ret_nickel,
  output logic                ret_penny,
  output logic                coin_reject,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);

`ifdef VEND_PENNY_EN
  localparam logic [3:0] RET_MASK = 4'b1111;
  logic penny_ok;
  assign penny_ok = penny;
`else
  // PRICE must be a multiple of 5 here, so change never needs a penny.
  localparam logic [3:0] RET_MASK = 4'b1110;
  logic penny_ok;
  assign penny_ok = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic [3:0]          ret_q, ret_d;
  logic                coin_reject_q, coin_reject_d;

  logic [CREDIT_W-1:0] coin_val;
  logic [2:0]          n_pulse;
  logic                any_pulse, multi_pulse, coin_fits;
  logic [3:0]          chg_sel;
  logic [CREDIT_W-1:0] chg_val;

  vend_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .credit   (credit_q),
    .coin_sel (chg_sel),
    .coin_val (chg_val)
  );

  always_comb begin
    coin_val = '0;
    if (quarter)       coin_val = CREDIT_W'(VAL_QUARTER);
    else if (dime)     coin_val = CREDIT_W'(VAL_DIME);
    else if (nickel)   coin_val = CREDIT_W'(VAL_NICKEL);
    else if (penny_ok) coin_val = CREDIT_W'(VAL_PENNY);
  end

  assign n_pulse     = 3'(penny) + 3'(nickel) + 3'(dime) + 3'(quarter);
  assign any_pulse   = (n_pulse != 3'd0);
  assign multi_pulse = (n_pulse > 3'd1);
  // Cannot wrap: credit never exceeds MAX_CREDIT and MAX_CREDIT + 25 fits.
  assign coin_fits   = (credit_q + coin_val) <= MAX_C;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    dispense_d    = 1'b0;
    ret_d         = '0;
    coin_reject_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // Leaving for VEND or CHANGE rejects any coin seen in the same cycle.
        if (state_q == ST_CREDIT && cancel) begin
          state_d       = ST_CHANGE;
          coin_reject_d = any_pulse;
        end else if (state_q == ST_CREDIT && vend_req && credit_q >= PRICE_C) begin
          state_d       = ST_VEND;
          credit_d      = credit_q - PRICE_C;
          dispense_d    = 1'b1;
          coin_reject_d = any_pulse;
        end else if (coin_val != '0 && coin_fits) begin
          state_d       = ST_CREDIT;
          credit_d      = credit_q + coin_val;
          coin_reject_d = multi_pulse;
        end else begin
          coin_reject_d = any_pulse;
        end
      end
      ST_VEND: begin
        state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
        coin_reject_d = any_pulse;
      end
      ST_CHANGE: begin
        coin_reject_d = any_pulse;
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          ret_d    = chg_sel & RET_MASK;
          credit_d = credit_q - chg_val;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge; all state, including every
  // pulse register, is cleared so an interrupted refund is simply dropped.
  // NOTE: non-blocking assignments keep every flop updating from the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      dispense_q    <= 1'b0;
      ret_q         <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      dispense_q    <= dispense_d;
      ret_q         <= ret_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign credit      = credit_q;
  assign dispense    = dispense_q;
  assign ret_quarter = ret_q[COIN_Q];
  assign ret_dime    = ret_q[COIN_D];
  assign ret_nickel  = ret_q[COIN_N];
  assign ret_penny   = ret_q[COIN_P];
  assign coin_reject = coin_reject_q;
  assign busy        = (state_q == ST_VEND) || (state_q == ST_CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: a transaction-level credit/change model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_vend_ctrl;

  localparam int PRICE      = 75;
  localparam int MAX_CREDIT = 200;
`ifdef VEND_PENNY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, penny, nickel, dime, quarter, vend_req, cancel;
  logic [7:0] credit;
  logic       dispense, ret_quarter, ret_dime, ret_nickel, ret_penny;
  logic       coin_reject, busy;

  vend_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .penny       (penny),
    .nickel      (nickel),
    .dime        (dime),
    .quarter     (quarter),
    .vend_req    (vend_req),
    .cancel      (cancel),
    .credit      (credit),
    .dispense    (dispense),
    .ret_quarter (ret_quarter),
    .ret_dime    (ret_dime),
    .ret_nickel  (ret_nickel),
    .ret_penny   (ret_penny),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: credit in cents, a coarse mode, and the full change list computed
  // up front by division whenever a refund becomes due.
  typedef enum {M_IDLE, M_CREDIT, M_VEND, M_CHANGE} mode_e;
  mode_e    m_mode = M_IDLE;
  int       m_credit = 0;
  int       m_q[$];
  bit       e_disp, e_rej;
  bit [3:0] e_ret;  // {quarter, dime, nickel, penny}

  int n_retq = 0, n_ret_all = 0;

  task automatic fill_change(input int c);
    m_q.delete();
    repeat (c / 25) m_q.push_back(25);
    c = c % 25;
    repeat (c / 10) m_q.push_back(10);
    c = c % 10;
    repeat (c / 5) m_q.push_back(5);
    c = c % 5;
    repeat (c) m_q.push_back(1);
  endtask

  task automatic model_step();
    int n, best, v;
    e_disp = 1'b0;
    e_ret  = 4'b0;
    e_rej  = 1'b0;
    if (reset) begin
      m_credit = 0;
      m_mode   = M_IDLE;
      m_q.delete();
      return;
    end
    n    = int'(penny) + int'(nickel) + int'(dime) + int'(quarter);
    best = quarter ? 25 : dime ? 10 : nickel ? 5 : (penny && PEN) ? 1 : 0;
    case (m_mode)
      M_IDLE, M_CREDIT: begin
        if (m_mode == M_CREDIT && cancel) begin
          e_rej = (n > 0);
          fill_change(m_credit);
          m_mode = M_CHANGE;
        end else if (m_mode == M_CREDIT && vend_req && m_credit >= PRICE) begin
          e_rej    = (n > 0);
          m_credit = m_credit - PRICE;
          e_disp   = 1'b1;
          fill_change(m_credit);
          m_mode = M_VEND;
        end else if (best > 0 && m_credit + best <= MAX_CREDIT) begin
          m_credit = m_credit + best;
          m_mode   = M_CREDIT;
          e_rej    = (n > 1);
        end else begin
          e_rej = (n > 0);
        end
      end
      M_VEND: begin
        e_rej  = (n > 0);
        m_mode = (m_q.size() > 0) ? M_CHANGE : M_IDLE;
      end
      M_CHANGE: begin
        e_rej = (n > 0);
        if (m_q.size() == 0) begin
          m_mode = M_IDLE;
        end else begin
          v = m_q.pop_front();
          m_credit = m_credit - v;
          e_ret = (v == 25) ? 4'b1000 : (v == 10) ? 4'b0100 : (v == 5) ? 4'b0010 : 4'b0001;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock: advance the model on the current inputs, then compare every
  // output at the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("credit", {24'b0, credit}, m_credit);
    check("outputs", {25'b0, dispense, ret_quarter, ret_dime, ret_nickel, ret_penny, coin_reject, busy},
          {25'b0, e_disp, e_ret, e_rej, (m_mode == M_VEND || m_mode == M_CHANGE)});
    n_retq    += int'(ret_quarter);
    n_ret_all += int'(ret_quarter) + int'(ret_dime) + int'(ret_nickel) + int'(ret_penny);
  endtask

  // coins = {quarter, dime, nickel, penny}
  task automatic step(input bit [3:0] coins, input bit vr, input bit cn, input bit rst);
    {quarter, dime, nickel, penny} = coins;
    vend_req = vr;
    cancel   = cn;
    reset    = rst;
    tick();
    {quarter, dime, nickel, penny, vend_req, cancel, reset} = '0;
  endtask

  task automatic idle_step();
    step(4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      idle_step();
      k++;
    end
    check("reach_idle", busy, 1'b0);
  endtask

  int       rq0, ra0;
  bit [3:0] chg_exp[$];

  initial begin
    {quarter, dime, nickel, penny, vend_req, cancel} = '0;
    reset = 1'b1;
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0, 1'b1);  // coin during reset: discarded silently
    check("rst_credit", credit, 8'd0);
    check("rst_reject", coin_reject, 1'b0);

    // Exact price: three quarters then vend, no change.
    ra0 = n_ret_all;
    repeat (3) step(4'b1000, 1'b0, 1'b0, 1'b0);
    check("q3_credit", credit, 8'd75);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    check("q3_dispense", dispense, 1'b1);
    check("q3_remainder", credit, 8'd0);
    wait_idle(10);
    check("q3_no_change", n_ret_all - ra0, 0);

    // Overpay by one quarter; a dime inserted during VEND is rejected.
    rq0 = n_retq;
    repeat (4) step(4'b1000, 1'b0, 1'b0, 1'b0);
    check("q4_credit", credit, 8'd100);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    check("vend_coin_reject", coin_reject, 1'b1);
    wait_idle(10);
    check("q4_one_quarter", n_retq - rq0, 1);
    check("q4_final_credit", credit, 8'd0);

    // Small change refund in greedy order.
`ifdef VEND_PENNY_EN
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    check("dnpp_credit", credit, 8'd17);
    chg_exp = '{4'b0100, 4'b0010, 4'b0001, 4'b0001};
`else
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    check("penny_reject", coin_reject, 1'b1);
    check("penny_credit", credit, 8'd0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    check("dn_credit", credit, 8'd15);
    chg_exp = '{4'b0100, 4'b0010};
`endif
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    foreach (chg_exp[i]) begin
      idle_step();
      check("change_seq", {ret_quarter, ret_dime, ret_nickel, ret_penny}, chg_exp[i]);
    end
    wait_idle(10);

    // vend_req below price is ignored.
    step(4'b1000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    check("low_vend_credit", credit, 8'd25);
    check("low_vend_busy", busy, 1'b0);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    wait_idle(10);

    // Credit ceiling: 190, a quarter overflows, dime+nickel fits exactly.
    repeat (7) step(4'b1000, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    check("c190_credit", credit, 8'd190);
    step(4'b1000, 1'b0, 1'b0, 1'b0);
    check("c190_reject", coin_reject, 1'b1);
    check("c190_hold", credit, 8'd190);
    step(4'b0110, 1'b0, 1'b0, 1'b0);
    check("c200_credit", credit, 8'd200);
    check("c200_reject", coin_reject, 1'b1);
    rq0 = n_retq;
    step(4'b1000, 1'b1, 1'b1, 1'b0);  // cancel beats vend_req and the coin
    check("cancel_reject", coin_reject, 1'b1);
    check("cancel_no_disp", dispense, 1'b0);
    wait_idle(20);
    check("c200_quarters", n_retq - rq0, 8);

    // Reset mid-refund drops the remaining change.
    repeat (4) step(4'b1000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    begin
      int k = 0;
      while (!ret_quarter && k < 5) begin
        idle_step();
        k++;
      end
    end
    check("rst_mid_first_q", ret_quarter, 1'b1);
    ra0 = n_ret_all;
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    check("rst_mid_credit", credit, 8'd0);
    check("rst_mid_busy", busy, 1'b0);
    repeat (3) idle_step();
    check("rst_mid_no_ret", n_ret_all - ra0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
